// File: rtl/tri_buffer_bank.sv
// Three-bank frame buffer: captures RX bytes into one bank while
// replaying another bank's recorded frame to TX over valid/ready.
module tri_buffer_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        sram_select,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              frame_done,
  output logic              wr_overflow,
  output logic              sel_err,
  output logic [1:0]        wr_bank,
  output logic [1:0]        rd_bank
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [2:0] {
    R_IDLE,
    R_FETCH,
    R_LOAD,
    R_SEND,
    R_DONE
  } rstate_t;

  rstate_t state, nstate;

  logic [2:0]        sel_q;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   len [3];
  logic [ADDR_W:0]   len_snap;
  logic [ADDR_W:0]   rd_addr;
  logic [ADDR_W:0]   rd_nxt;
  logic [DATA_W-1:0] mem [3][DEPTH];
  logic [DATA_W-1:0] q;
  logic              restart;
  logic              legal;
  logic              sw;
  logic              wr_en;
  logic              hs;
  logic              last;

  always_comb begin
    wr_bank = 2'd0;
    rd_bank = 2'd1;
    unique case (sel_q)
      3'b000: begin wr_bank = 2'd0; rd_bank = 2'd1; end
      3'b001: begin wr_bank = 2'd0; rd_bank = 2'd2; end
      3'b010: begin wr_bank = 2'd1; rd_bank = 2'd0; end
      3'b011: begin wr_bank = 2'd1; rd_bank = 2'd2; end
      3'b100: begin wr_bank = 2'd2; rd_bank = 2'd0; end
      3'b101: begin wr_bank = 2'd2; rd_bank = 2'd1; end
      default: ;
    endcase
  end

  assign legal  = !(sram_select[2] && sram_select[1]);
  assign sw     = legal && (sram_select != sel_q);
  assign wr_en  = wr_valid && !wr_cnt[ADDR_W];
  assign hs     = (state == R_SEND) && tx_ready;
  assign rd_nxt = rd_addr + 1'b1;
  assign last   = (rd_nxt == len_snap);

  // Storage has no reset; only lengths gate what is replayed
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_bank][wr_cnt[ADDR_W-1:0]] <= wr_data;
    if (state == R_FETCH)
      q <= mem[rd_bank][rd_addr[ADDR_W-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q       <= 3'b000;
      sel_err     <= 1'b0;
      wr_cnt      <= '0;
      wr_overflow <= 1'b0;
      for (int i = 0; i < 3; i++)
        len[i] <= '0;
    end else begin
      if (!legal)
        sel_err <= 1'b1;
      if (sw) begin
        sel_q       <= sram_select;
        len[wr_bank] <= wr_cnt + {{ADDR_W{1'b0}}, wr_en};
        wr_cnt      <= '0;
        wr_overflow <= 1'b0;
      end else begin
        if (wr_en)
          wr_cnt <= wr_cnt + 1'b1;
        if (wr_valid && wr_cnt[ADDR_W])
          wr_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= R_IDLE;
    else
      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      R_IDLE:
        if (restart)
          nstate = (len[rd_bank] == '0) ? R_DONE : R_FETCH;
      R_FETCH: nstate = R_LOAD;
      R_LOAD:  nstate = R_SEND;
      R_SEND:
        if (tx_ready)
          nstate = restart ? R_IDLE : (last ? R_DONE : R_FETCH);
      R_DONE:
        if (restart)
          nstate = R_IDLE;
      default: nstate = R_IDLE;
    endcase
  end

  // A switch arriving while idle re-arms the flag for the next pass
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      restart    <= 1'b0;
      rd_addr    <= '0;
      len_snap   <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (sw)
        restart <= 1'b1;
      else if (state == R_IDLE)
        restart <= 1'b0;
      if (state == R_IDLE && restart) begin
        rd_addr  <= '0;
        len_snap <= len[rd_bank];
      end
      if (state == R_LOAD) begin
        tx_data  <= q;
        tx_valid <= 1'b1;
      end
      if (hs) begin
        tx_valid   <= 1'b0;
        rd_addr    <= rd_nxt;
        frame_done <= last;
      end
    end
  end

endmodule

// File: tb/tb_tri_buffer_bank.sv
// Directed/random bench for tri_buffer_bank with a bank-level
// reference model built from byte queues.
module tb_tri_buffer_bank;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int DEPTH = 2**AW;

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    sram_select;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          frame_done;
  logic          wr_overflow;
  logic          sel_err;
  logic [1:0]    wr_bank;
  logic [1:0]    rd_bank;

  tri_buffer_bank #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .sram_select (sram_select),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .frame_done  (frame_done),
    .wr_overflow (wr_overflow),
    .sel_err     (sel_err),
    .wr_bank     (wr_bank),
    .rd_bank     (rd_bank)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int cap_of [6] = '{0, 0, 1, 1, 2, 2};
  int tx_of  [6] = '{1, 2, 0, 2, 0, 1};

  int       sel_m;
  bit       ovf_m;
  bit       err_m;
  byte_q_t  cur;
  byte_q_t  frames [3];
  byte_q_t  exp_q;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    sel_m = 0;
    ovf_m = 0;
    err_m = 0;
    cur = {};
    for (int i = 0; i < 3; i++)
      frames[i] = {};
  endtask

  task automatic model_wr(input logic [7:0] d);
    if (cur.size() < DEPTH)
      cur.push_back(d);
    else
      ovf_m = 1;
  endtask

  task automatic wr_one(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    model_wr(d);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic sel_to(input logic [2:0] code, input bit with_wr,
                        input logic [7:0] d);
    sram_select = code;
    wr_valid = with_wr;
    wr_data = d;
    if (code >= 3'd6) begin
      err_m = 1;
    end else if (int'(code) != sel_m) begin
      if (with_wr && cur.size() < DEPTH)
        cur.push_back(d);
      frames[cap_of[sel_m]] = cur;
      cur = {};
      ovf_m = 0;
      sel_m = int'(code);
    end else if (with_wr) begin
      model_wr(d);
    end
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!tx_valid && n < 50) begin
      step();
      n++;
    end
    chk(tag, {31'd0, tx_valid}, 32'd1);
  endtask

  task automatic drain(input int start, input int pct, input int exp_done);
    int idx = start;
    int dones = 0;
    int extra = 0;
    int cyc = 0;
    int n = exp_q.size();
    bit rdy;
    while (cyc < 1000 && extra < 6) begin
      if (frame_done) begin
        dones++;
        chk("done_pos", idx, n);
      end
      if (idx >= n)
        extra++;
      rdy = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      tx_ready = rdy;
      if (tx_valid && rdy) begin
        if (idx < n)
          chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q[idx]});
        else
          chk("extra_byte", {31'd0, tx_valid}, 32'd0);
        idx++;
      end
      step();
      cyc++;
    end
    tx_ready = 1'b0;
    chk("n_bytes", idx, n);
    chk("n_done", dones, exp_done);
    chk("idle", {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic chk_banks(input string tag);
    chk({tag, "_wr"}, {30'd0, wr_bank}, cap_of[sel_m]);
    chk({tag, "_rd"}, {30'd0, rd_bank}, tx_of[sel_m]);
    chk({tag, "_ovf"}, {31'd0, wr_overflow}, {31'd0, ovf_m});
    chk({tag, "_err"}, {31'd0, sel_err}, {31'd0, err_m});
  endtask

  initial begin
    reset = 1'b0;
    sram_select = 3'b000;
    wr_valid = 1'b0;
    wr_data = '0;
    tx_ready = 1'b0;
    model_reset();
    step();
    step();
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk_banks("rst");
    reset = 1'b1;
    step();

    // basic replay of three bytes
    wr_one(8'h11);
    wr_one(8'h22);
    wr_one(8'h33);
    sel_to(3'b010, 0, 8'h00);
    chk_banks("sw1");
    exp_q = frames[0];
    chk("frame_len", exp_q.size(), 3);
    drain(0, 100, 1);

    // stall: data held while tx_ready is low
    for (int i = 0; i < 5; i++)
      wr_one(8'($urandom));
    sel_to(3'b000, 0, 8'h00);
    exp_q = frames[1];
    wait_valid("stall_wait");
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", {31'd0, tx_valid}, 32'd1);
      chk("stall_data", {24'd0, tx_data}, {24'd0, exp_q[0]});
      step();
    end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("one_acc", {31'd0, tx_valid}, 32'd0);
    drain(1, 50, 1);

    // overflow: 65 bytes into a 64-byte bank
    for (int i = 0; i < DEPTH + 1; i++)
      wr_one(8'($urandom));
    chk("ovf_set", {31'd0, wr_overflow}, 32'd1);
    chk("ovf_model", {31'd0, wr_overflow}, {31'd0, ovf_m});
    sel_to(3'b010, 0, 8'h00);
    chk_banks("sw_ovf");
    exp_q = frames[0];
    chk("len_full", exp_q.size(), DEPTH);

    // mid-frame switch with a pending byte
    for (int i = 0; i < 2; i++) begin
      wait_valid("mid_wait");
      chk("mid_byte", {24'd0, tx_data}, {24'd0, exp_q[i]});
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
    end
    wait_valid("pend_wait");
    wr_one(8'($urandom));
    wr_one(8'($urandom));
    chk("pend_hold", {24'd0, tx_data}, {24'd0, exp_q[2]});
    sel_to(3'b100, 1, 8'($urandom));
    chk_banks("sw_mid");
    for (int i = 0; i < 4; i++) begin
      chk("pend_valid", {31'd0, tx_valid}, 32'd1);
      chk("pend_data", {24'd0, tx_data}, {24'd0, exp_q[2]});
      step();
    end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("pend_nodone", {31'd0, frame_done}, 32'd0);
    exp_q = frames[0];
    drain(0, 80, 1);

    // bytes including the switch-cycle write replay from bank Y
    sel_to(3'b101, 0, 8'h00);
    chk_banks("sw_y");
    exp_q = frames[1];
    chk("y_len", exp_q.size(), 3);
    drain(0, 100, 1);

    // illegal select is sticky and leaves mapping alone
    sel_to(3'b111, 0, 8'h00);
    chk_banks("ill");
    sel_to(3'b101, 0, 8'h00);
    chk_banks("ill_back");
    step();
    chk("ill_novalid", {31'd0, tx_valid}, 32'd0);

    // empty bank: nothing replayed
    sel_to(3'b011, 0, 8'h00);
    chk_banks("sw_empty");
    exp_q = frames[2];
    drain(0, 100, 0);

    // reset aborts a pending byte
    for (int i = 0; i < 3; i++)
      wr_one(8'($urandom));
    sel_to(3'b101, 0, 8'h00);
    wait_valid("abort_wait");
    chk("abort_pre", {24'd0, tx_data}, {24'd0, frames[1][0]});
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("abort_valid", {31'd0, tx_valid}, 32'd0);
    chk("abort_data", {24'd0, tx_data}, 32'd0);
    sram_select = 3'b000;
    step();
    chk_banks("abort");
    reset = 1'b1;
    step();
    step();
    chk("post_rst_valid", {31'd0, tx_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
